sample_streamer: RTL and testbench



---
 rtl/sample_streamer_pkg.sv | 27 ++
 rtl/sample_streamer_sample_ram.sv | 47 ++++
 rtl/sample_streamer.sv | 186 ++++++++++++++++++
 tb/tb_sample_streamer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_streamer_pkg.sv
// ---------------------------------------------------------------------------
// sample_streamer_pkg
// Shared definitions for the sample streamer and the accumulator it feeds.
// Both blocks take the batch length and sample width from here so that the
// number of streamed samples always matches the accumulator's iteration count.
//
// Contents:
//   SS_DATA_W    - sample width in bits
//   SS_N_SAMPLES - samples per batch
//   SS_ADDR_W    - buffer index width, smallest width holding SS_N_SAMPLES entries
//   state_e      - streamer FSM state encoding (LOAD, FULL, RUN, DONE)
// ---------------------------------------------------------------------------
package sample_streamer_pkg;

    localparam int SS_DATA_W    = 32;
    localparam int SS_N_SAMPLES = 100;
    // A one-entry batch still needs a one-bit index.
    localparam int SS_ADDR_W    = (SS_N_SAMPLES > 1) ? $clog2(SS_N_SAMPLES) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FULL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : sample_streamer_pkg

// File: rtl/sample_streamer_sample_ram.sv
// ---------------------------------------------------------------------------
// sample_ram
// Simple dual-port RAM, DATA_W x 2**ADDR_W, used as the streamer's batch
// buffer. Contents are not reset; only written locations are ever read.
//
// Ports:
//   clk      - clock
//   wr_en    - write strobe, writes wr_data to wr_addr on the rising edge
//   wr_addr  - write index
//   wr_data  - write data
//   rd_en    - read strobe; when low the read register keeps its value
//   rd_addr  - read index
//   rd_data  - registered read data, valid the cycle after rd_en
// ---------------------------------------------------------------------------
module sample_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Gating the read register with rd_en lets the streamer freeze the
    // sample in flight while it is paused.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule : sample_ram

// File: rtl/sample_streamer.sv
// ---------------------------------------------------------------------------
// sample_streamer
// Buffers one batch of N_SAMPLES samples written by the host over a
// valid/ready port, then on start streams them out in write order as (x, en),
// one sample per non-held cycle. en is high for exactly N_SAMPLES cycles per
// batch, followed by a one-cycle done pulse.
//
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset
//   wr_valid  - host sample valid
//   wr_ready  - streamer accepts a sample (registered, high in LOAD until full)
//   wr_data   - host sample, stored bit-exact
//   start     - begin streaming a full batch (honoured only in FULL)
//   hold      - pause streaming without losing or repeating a sample
//   busy      - high while streaming (RUN)
//   done      - one-cycle pulse after the last sample
//   x         - registered sample to the accumulator
//   en        - registered valid for x
// ---------------------------------------------------------------------------
module sample_streamer
    import sample_streamer_pkg::*;
#(
    parameter int DATA_W    = SS_DATA_W,
    parameter int N_SAMPLES = SS_N_SAMPLES,
    parameter int ADDR_W    = SS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] x,
    output logic              en
);

    if (N_SAMPLES > 2**ADDR_W) begin : g_addr_check
        $error("sample_streamer: N_SAMPLES does not fit in ADDR_W index bits");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [ADDR_W:0]   N_EXT     = (ADDR_W + 1)'(N_SAMPLES);

    state_e             state_q,    state_d;
    logic [ADDR_W-1:0]  wr_cnt_q,   wr_cnt_d;
    logic [ADDR_W-1:0]  rd_idx_q,   rd_idx_d;
    // rd_all: every index has been read; rd_vld: RAM output holds an unsent sample.
    logic               rd_all_q,   rd_all_d;
    logic               rd_vld_q,   rd_vld_d;
    logic               wr_ready_q, wr_ready_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               en_q,       en_d;
    logic [DATA_W-1:0]  x_q,        x_d;

    logic               ram_we;
    logic               ram_re;
    logic [DATA_W-1:0]  ram_rd_data;

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_cnt_q),
        .wr_data (wr_data),
        .rd_en   (ram_re),
        .rd_addr (rd_idx_q),
        .rd_data (ram_rd_data)
    );

    // Next-state logic. The stream is a two-stage pipeline: a read issued on
    // one edge lands in the RAM output register, and the following non-held
    // edge moves it into x with en. Under hold both stages freeze, so the
    // sample sitting in the RAM register is sent first on release.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_idx_d = rd_idx_q;
        rd_all_d = rd_all_q;
        rd_vld_d = rd_vld_q;
        done_d   = 1'b0;
        en_d     = 1'b0;
        x_d      = x_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;

        case (state_q)
            LOAD: begin
                if (wr_valid && wr_ready_q) begin
                    ram_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d = FULL;
                    end
                end
            end

            FULL: begin
                if (start) begin
                    state_d  = RUN;
                    rd_idx_d = '0;
                    rd_all_d = 1'b0;
                    rd_vld_d = 1'b0;
                end
            end

            RUN: begin
                if (rd_all_q && !rd_vld_q) begin
                    // Pipeline empty: the previous edge sent the last sample.
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!hold) begin
                    en_d = rd_vld_q;
                    if (rd_vld_q) begin
                        x_d = ram_rd_data;
                    end
                    if (!rd_all_q) begin
                        ram_re   = 1'b1;
                        rd_vld_d = 1'b1;
                        // rd_idx stops at the last index so it never wraps.
                        if (rd_idx_q == LAST_IDX) begin
                            rd_all_d = 1'b1;
                        end else begin
                            rd_idx_d = rd_idx_q + 1'b1;
                        end
                    end else begin
                        rd_vld_d = 1'b0;
                    end
                end
            end

            DONE: begin
                state_d  = LOAD;
                wr_cnt_d = '0;
            end

            default: begin
                state_d = LOAD;
            end
        endcase

        // Registered outputs are derived from the next state so they line up
        // with the state they describe.
        wr_ready_d = (state_d == LOAD) && ({1'b0, wr_cnt_d} < N_EXT);
        busy_d     = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            wr_cnt_q   <= '0;
            rd_idx_q   <= '0;
            rd_all_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            en_q       <= 1'b0;
            x_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_idx_q   <= rd_idx_d;
            rd_all_q   <= rd_all_d;
            rd_vld_q   <= rd_vld_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            en_q       <= en_d;
            x_q        <= x_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign en       = en_q;
    assign x        = x_q;

endmodule : sample_streamer

// File: tb/tb_sample_streamer.sv
// ---------------------------------------------------------------------------
// tb_sample_streamer
// Directed testbench for sample_streamer. Each scenario fills a reference
// batch, writes it into the streamer, then checks cycle by cycle that the
// stream comes out in order with the expected latency, hold behaviour and
// done pulse.
// ---------------------------------------------------------------------------
module tb_sample_streamer;

    localparam int N = 100;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        start;
    logic        hold;
    logic        busy;
    logic        done;
    logic [31:0] x;
    logic        en;

    logic [31:0] batch [N];
    int          checks;
    int          errors;

    sample_streamer dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .start    (start),
        .hold     (hold),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .en       (en)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario ever stalls.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one observed value against its expected value and counts it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs
    // are sampled here, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_en",       32'(en),       32'd0);
        checkOutput("rst_done",     32'(done),     32'd0);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("rst_x",        x,             32'd0);
    endtask

    // Writes batch[first .. first+count-1] with wr_valid held high.
    task automatic applyStimulus(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            checkOutput("wr_ready_load", 32'(wr_ready), 32'd1);
            wr_valid = 1'b1;
            wr_data  = batch[i];
            tick();
        end
        wr_valid = 1'b0;
        wr_data  = 32'h0;
    endtask

    // Pulses start and checks the whole stream. When holdIdx >= 0, hold is
    // raised right after the en cycle of batch[holdIdx] for holdLen cycles.
    task automatic runBatch(input int holdIdx, input int holdLen);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("en_latency0",      32'(en),   32'd0);
        tick();
        checkOutput("en_latency1",      32'(en),   32'd0);
        for (int i = 0; i < N; i++) begin
            tick();
            checkOutput("en_burst", 32'(en), 32'd1);
            checkOutput("x_order",  x,       batch[i]);
            checkOutput("done_early", 32'(done), 32'd0);
            if (i == holdIdx) begin
                hold = 1'b1;
                for (int h = 0; h < holdLen; h++) begin
                    tick();
                    checkOutput("hold_en", 32'(en), 32'd0);
                    checkOutput("hold_x",  x,       batch[i]);
                end
                hold = 1'b0;
            end
        end
        tick();
        checkOutput("done_pulse", 32'(done),     32'd1);
        checkOutput("done_en",    32'(en),       32'd0);
        checkOutput("done_busy",  32'(busy),     32'd0);
        tick();
        checkOutput("done_clear", 32'(done),     32'd0);
        checkOutput("post_ready", 32'(wr_ready), 32'd1);
        checkOutput("post_en",    32'(en),       32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 32'h0;
        start    = 1'b0;
        hold     = 1'b0;

        // Basic batch 1..100.
        doReset();
        for (int i = 0; i < N; i++) batch[i] = 32'(i + 1);
        applyStimulus(0, N);
        checkOutput("full_ready", 32'(wr_ready), 32'd0);
        runBatch(-1, 0);

        // start while only half loaded is ignored; hold in LOAD does nothing.
        for (int i = 0; i < N; i++) batch[i] = 32'h0000_0A00 + 32'(i);
        applyStimulus(0, 50);
        start = 1'b1;
        hold  = 1'b1;
        tick();
        start = 1'b0;
        hold  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("partial_en",   32'(en),       32'd0);
            checkOutput("partial_busy", 32'(busy),     32'd0);
        end
        checkOutput("partial_ready", 32'(wr_ready), 32'd1);
        applyStimulus(50, 50);
        checkOutput("full_ready2", 32'(wr_ready), 32'd0);
        // A write offered alongside start in FULL must not be taken.
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        runBatch(-1, 0);
        wr_valid = 1'b0;

        // Hold for 3 cycles after the x=50 sample.
        for (int i = 0; i < N; i++) batch[i] = 32'(i);
        applyStimulus(0, N);
        runBatch(50, 3);

        // Extreme bit patterns pass through unchanged.
        for (int i = 0; i < N; i++) batch[i] = 32'h1234_0000 ^ 32'(i * 7);
        batch[0]  = 32'hFFFF_FFFF;
        batch[1]  = 32'h8000_0000;
        batch[2]  = 32'h7FFF_FFFF;
        batch[3]  = 32'h0000_0000;
        batch[98] = 32'h8000_0000;
        batch[99] = 32'hFFFF_FFFF;
        applyStimulus(0, N);
        runBatch(-1, 0);

        // Reset in RUN after 40 en cycles abandons the stream.
        for (int i = 0; i < N; i++) batch[i] = 32'h0000_0B00 + 32'(i);
        applyStimulus(0, N);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            checkOutput("abort_x", x, batch[i]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_en",    32'(en),       32'd0);
        checkOutput("abort_done",  32'(done),     32'd0);
        checkOutput("abort_busy",  32'(busy),     32'd0);
        checkOutput("abort_ready", 32'(wr_ready), 32'd1);
        tick();
        checkOutput("abort_en2",   32'(en),       32'd0);
        for (int i = 0; i < N; i++) batch[i] = 32'h0000_0C00 + 32'(i);
        applyStimulus(0, N);
        runBatch(-1, 0);

        // Back-to-back batches A and B.
        for (int i = 0; i < N; i++) batch[i] = 32'h1000_0000 + 32'(i);
        applyStimulus(0, N);
        runBatch(-1, 0);
        for (int i = 0; i < N; i++) batch[i] = 32'h2000_0000 + 32'(i);
        applyStimulus(0, N);
        runBatch(-1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sample_streamer
